// File: rtl/exec_completion_arbiter_if.sv
// ---------------------------------------------------------------------------
// exec_completion_arbiter_if
//
// Bundle between the execute-stage completion sources and the completion
// arbiter, plus the arbiter's serialised output toward the CDB broadcaster.
//
//   flush         : synchronous squash of all pending completions
//   src_valid     : per-source completion strobe
//   src_tag       : per-source PRF tag, source i at [i*TAG_W +: TAG_W]
//   src_ready     : per-source FIFO not full
//   exec_done     : registered completion valid
//   exec_dest_prf : registered completion tag
//   pending_cnt   : total queued entries
//
// Modports: master = execute stage / testbench side, slave = arbiter.
// ---------------------------------------------------------------------------
interface exec_completion_arbiter_if #(
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 6
);
  localparam int PEND_W = $clog2(NUM_SRC * DEPTH + 1);

  logic                     flush;
  logic [NUM_SRC-1:0]       src_valid;
  logic [NUM_SRC*TAG_W-1:0] src_tag;
  logic [NUM_SRC-1:0]       src_ready;
  logic                     exec_done;
  logic [TAG_W-1:0]         exec_dest_prf;
  logic [PEND_W-1:0]        pending_cnt;

  modport master (
    output flush, src_valid, src_tag,
    input  src_ready, exec_done, exec_dest_prf, pending_cnt
  );

  modport slave (
    input  flush, src_valid, src_tag,
    output src_ready, exec_done, exec_dest_prf, pending_cnt
  );
endinterface

// File: rtl/exec_completion_arbiter.sv
// ---------------------------------------------------------------------------
// exec_completion_arbiter
//
// Collects completion tags from NUM_SRC functional units into one small FIFO
// per source and drains one completion per cycle, round-robin, into the
// registered exec_done / exec_dest_prf pair feeding the CDB broadcaster.
//
// Ports:
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : exec_completion_arbiter_if.slave (sources in, completion out)
//
// Optional feature macro: COMPLETION_BYPASS_EN
//   When defined and every FIFO is empty, the incoming sources are arbitrated
//   directly and the winner's tag goes straight to the output register
//   (latency 1); losers enqueue normally. When undefined every completion
//   takes the queued path (latency 2).
// ---------------------------------------------------------------------------
module exec_completion_arbiter #(
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 6
) (
  input logic                     clk,
  input logic                     reset_n,
  exec_completion_arbiter_if.slave bus
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int RR_W   = $clog2(NUM_SRC);
  localparam int PEND_W = $clog2(NUM_SRC * DEPTH + 1);

  logic [TAG_W-1:0]   mem    [NUM_SRC][DEPTH];
  logic [PTR_W-1:0]   wr_ptr [NUM_SRC];
  logic [PTR_W-1:0]   rd_ptr [NUM_SRC];
  logic [CNT_W-1:0]   cnt    [NUM_SRC];
  logic [RR_W-1:0]    rr_ptr;
  logic               done_q;
  logic [TAG_W-1:0]   tag_q;
  logic [PEND_W-1:0]  pend_q;

  logic [NUM_SRC-1:0] not_empty;
  logic [NUM_SRC-1:0] ready;
  logic [NUM_SRC-1:0] push_en;
  logic [NUM_SRC-1:0] pop_en;
  logic               gnt_vld;
  logic               byp_vld;
  logic               sel_vld;
  logic [RR_W-1:0]    gnt_idx;
  logic [RR_W-1:0]    byp_idx;
  logic [RR_W-1:0]    sel_idx;
  logic [TAG_W-1:0]   sel_tag;
  logic [PEND_W-1:0]  push_num;

  // First requester at or after ptr, wrapping modulo NUM_SRC. Scanning from
  // the farthest offset down lets the nearest requester overwrite the pick.
  function automatic logic [RR_W-1:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                               input logic [RR_W-1:0]    ptr);
    logic [RR_W:0]   pos;
    logic [RR_W-1:0] pick;
    pick = ptr;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + (RR_W+1)'(k);
      if (pos >= (RR_W+1)'(NUM_SRC)) pos = pos - (RR_W+1)'(NUM_SRC);
      if (req[pos[RR_W-1:0]]) pick = pos[RR_W-1:0];
    end
    return pick;
  endfunction

  function automatic logic [RR_W-1:0] rr_inc(input logic [RR_W-1:0] idx);
    return (idx == RR_W'(NUM_SRC - 1)) ? '0 : idx + 1'b1;
  endfunction

  // Ready looks only at the registered count, so a full FIFO refuses a push
  // even in the cycle it is being popped.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign not_empty[i] = (cnt[i] != '0);
    assign ready[i]     = (cnt[i] != CNT_W'(DEPTH));
    assign pop_en[i]    = gnt_vld && (gnt_idx == RR_W'(i));
  end

  assign gnt_vld = |not_empty;
  assign gnt_idx = rr_pick(not_empty, rr_ptr);

`ifdef COMPLETION_BYPASS_EN
  // All FIFOs empty: arbitrate the incoming strobes directly. Every source
  // is ready here because every count is zero.
  assign byp_vld = !gnt_vld && (|bus.src_valid);
  assign byp_idx = rr_pick(bus.src_valid, rr_ptr);
`else
  assign byp_vld = 1'b0;
  assign byp_idx = '0;
`endif

  assign sel_vld = gnt_vld | byp_vld;
  assign sel_idx = gnt_vld ? gnt_idx : byp_idx;
  assign sel_tag = gnt_vld ? mem[gnt_idx][rd_ptr[gnt_idx]]
                           : bus.src_tag[byp_idx*TAG_W +: TAG_W];

  // NOTE: every variable written in always_comb gets a default before the
  // loop, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    push_en  = '0;
    push_num = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      push_en[i] = bus.src_valid[i] && ready[i] &&
                   !(byp_vld && (byp_idx == RR_W'(i)));
      push_num   = push_num + PEND_W'(push_en[i]);
    end
  end

  // NOTE: the tag storage has no reset; the counts and pointers define which
  // entries are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (push_en[i]) mem[i][wr_ptr[i]] <= bus.src_tag[i*TAG_W +: TAG_W];
    end
  end

  // NOTE: state registers use non-blocking assignments so every update in
  // this block sees the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
      rr_ptr <= '0;
      done_q <= 1'b0;
      tag_q  <= '0;
      pend_q <= '0;
    end else if (bus.flush) begin
      // Squash everything, including pushes presented this cycle; the last
      // broadcast tag is simply held.
      for (int i = 0; i < NUM_SRC; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
      rr_ptr <= '0;
      done_q <= 1'b0;
      pend_q <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (push_en[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop_en[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        cnt[i] <= cnt[i] + CNT_W'(push_en[i]) - CNT_W'(pop_en[i]);
      end
      done_q <= sel_vld;
      if (sel_vld) begin
        tag_q  <= sel_tag;
        rr_ptr <= rr_inc(sel_idx);
      end
      pend_q <= pend_q + push_num - PEND_W'(gnt_vld);
    end
  end

  assign bus.src_ready     = ready;
  assign bus.exec_done     = done_q;
  assign bus.exec_dest_prf = tag_q;
  assign bus.pending_cnt   = pend_q;

endmodule

// File: tb/tb_exec_completion_arbiter.sv
// ---------------------------------------------------------------------------
// tb_exec_completion_arbiter
//
// Self-checking bench for exec_completion_arbiter: a directed vector table,
// hand-written multi-cycle sequences (fairness/full, flush, reset mid-drain)
// and randomized traffic, all compared against a queue-based reference
// model. Honours COMPLETION_BYPASS_EN when defined.
// ---------------------------------------------------------------------------
module tb_exec_completion_arbiter;
  localparam int NUM_SRC = 2;
  localparam int DEPTH   = 4;
  localparam int TAG_W   = 6;
  localparam int PEND_W  = $clog2(NUM_SRC * DEPTH + 1);
`ifdef COMPLETION_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  exec_completion_arbiter_if #(.NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

  exec_completion_arbiter #(.NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int               src;
    logic [TAG_W-1:0] tag;
  } ent_t;

  ent_t             mq[$];       // all queued entries, arrival order
  int               m_rr;
  logic             m_done;
  logic [TAG_W-1:0] m_tag;
  int               accepted;
  int               broadcast;
  logic [TAG_W-1:0] refused[$];
  logic [TAG_W-1:0] sent[$];
  bit               saw_not_ready;

  function automatic bit bit_at(input logic [NUM_SRC-1:0] vec, input int s);
    logic [NUM_SRC-1:0] sh;
    sh = vec >> s;
    return sh[0];
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [NUM_SRC*TAG_W-1:0] t, input int s);
    logic [NUM_SRC*TAG_W-1:0] sh;
    sh = t >> (s * TAG_W);
    return sh[TAG_W-1:0];
  endfunction

  function automatic int m_count(input int s);
    int n = 0;
    foreach (mq[i]) if (mq[i].src == s) n++;
    return n;
  endfunction

  function automatic logic [NUM_SRC-1:0] m_ready();
    logic [NUM_SRC-1:0] r = '0;
    for (int s = NUM_SRC - 1; s >= 0; s--) r = {r[NUM_SRC-2:0], m_count(s) < DEPTH};
    return r;
  endfunction

  function automatic logic [NUM_SRC-1:0] m_nonempty();
    logic [NUM_SRC-1:0] r = '0;
    for (int s = NUM_SRC - 1; s >= 0; s--) r = {r[NUM_SRC-2:0], m_count(s) > 0};
    return r;
  endfunction

  function automatic int rr_first(input logic [NUM_SRC-1:0] req, input int from);
    for (int k = 0; k < NUM_SRC; k++) begin
      if (bit_at(req, (from + k) % NUM_SRC)) return (from + k) % NUM_SRC;
    end
    return -1;
  endfunction

  task automatic m_clear();
    mq.delete();
    m_done = 1'b0;
    m_rr   = 0;
  endtask

  // One clock edge of the specified behaviour.
  task automatic m_step(input logic [NUM_SRC-1:0] v, input logic [NUM_SRC*TAG_W-1:0] t,
                        input logic f);
    logic [NUM_SRC-1:0] rdy;
    int                 g;
    int                 byp_src;
    if (f) begin
      m_clear();
      return;
    end
    rdy     = m_ready();
    byp_src = -1;
    g       = rr_first(m_nonempty(), m_rr);
    if (g >= 0) begin
      for (int i = 0; i < mq.size(); i++) begin
        if (mq[i].src == g) begin
          m_tag = mq[i].tag;
          mq.delete(i);
          break;
        end
      end
      m_done = 1'b1;
      m_rr   = (g + 1) % NUM_SRC;
    end else if (BYP && v != '0) begin
      g       = rr_first(v, m_rr);
      byp_src = g;
      m_tag   = tag_of(t, g);
      m_done  = 1'b1;
      m_rr    = (g + 1) % NUM_SRC;
    end else begin
      m_done = 1'b0;
    end
    for (int s = 0; s < NUM_SRC; s++) begin
      if (bit_at(v, s)) begin
        if (bit_at(rdy, s)) begin
          accepted++;
          if (s != byp_src) mq.push_back('{src: s, tag: tag_of(t, s)});
        end else begin
          refused.push_back(tag_of(t, s));
        end
      end
    end
  endtask

  // ---------------- drivers ----------------
  // Called at a falling edge: drive, check ready, clock, check outputs.
  task automatic step(input logic [NUM_SRC-1:0] v, input logic [NUM_SRC*TAG_W-1:0] t,
                      input logic f);
    bus.src_valid = v;
    bus.src_tag   = t;
    bus.flush     = f;
    #1;
    check("src_ready", 32'(bus.src_ready), 32'(m_ready()));
    if (bus.src_ready != '1) saw_not_ready = 1'b1;
    @(posedge clk);
    m_step(v, t, f);
    @(negedge clk);
    bus.src_valid = '0;
    bus.flush     = 1'b0;
    check("exec_done", 32'(bus.exec_done), 32'(m_done));
    check("exec_dest_prf", 32'(bus.exec_dest_prf), 32'(m_tag));
    check("pending_cnt", 32'(bus.pending_cnt), 32'(mq.size()));
    if (bus.exec_done === 1'b1) begin
      broadcast++;
      sent.push_back(bus.exec_dest_prf);
    end
  endtask

  task automatic do_reset();
    reset_n       = 1'b0;
    bus.src_valid = '0;
    bus.src_tag   = '0;
    bus.flush     = 1'b0;
    m_clear();
    m_tag = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step('0, '0, 1'b0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [NUM_SRC-1:0]       v;
    logic [NUM_SRC*TAG_W-1:0] t;
    logic                     exp_done;
    logic [TAG_W-1:0]         exp_tag;
    logic [PEND_W-1:0]        exp_pend;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] v, input logic [5:0] t1, input logic [5:0] t0,
                              input logic d, input logic [5:0] tag, input logic [3:0] pend);
    vec_t r;
    r.v = v; r.t = {t1, t0}; r.exp_done = d; r.exp_tag = tag; r.exp_pend = pend;
    return r;
  endfunction

  vec_t vt[11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lim;
    int hit;
    logic [5:0] seq;

`ifdef COMPLETION_BYPASS_EN
    vt[0]  = mk(2'b11, 6'h2A, 6'h03, 1'b1, 6'h03, 4'd1);
    vt[1]  = mk(2'b00, 6'h00, 6'h00, 1'b1, 6'h2A, 4'd0);
    vt[2]  = mk(2'b00, 6'h00, 6'h00, 1'b0, 6'h2A, 4'd0);
    vt[3]  = mk(2'b00, 6'h00, 6'h00, 1'b0, 6'h2A, 4'd0);
    vt[4]  = mk(2'b01, 6'h00, 6'h15, 1'b1, 6'h15, 4'd0);
    vt[5]  = mk(2'b00, 6'h00, 6'h00, 1'b0, 6'h15, 4'd0);
    vt[6]  = mk(2'b00, 6'h00, 6'h00, 1'b0, 6'h15, 4'd0);
    vt[7]  = mk(2'b11, 6'h02, 6'h01, 1'b1, 6'h02, 4'd1);
    vt[8]  = mk(2'b00, 6'h00, 6'h00, 1'b1, 6'h01, 4'd0);
    vt[9]  = mk(2'b00, 6'h00, 6'h00, 1'b0, 6'h01, 4'd0);
    vt[10] = mk(2'b00, 6'h00, 6'h00, 1'b0, 6'h01, 4'd0);
`else
    vt[0]  = mk(2'b11, 6'h2A, 6'h03, 1'b0, 6'h00, 4'd2);
    vt[1]  = mk(2'b00, 6'h00, 6'h00, 1'b1, 6'h03, 4'd1);
    vt[2]  = mk(2'b00, 6'h00, 6'h00, 1'b1, 6'h2A, 4'd0);
    vt[3]  = mk(2'b00, 6'h00, 6'h00, 1'b0, 6'h2A, 4'd0);
    vt[4]  = mk(2'b01, 6'h00, 6'h15, 1'b0, 6'h2A, 4'd1);
    vt[5]  = mk(2'b00, 6'h00, 6'h00, 1'b1, 6'h15, 4'd0);
    vt[6]  = mk(2'b00, 6'h00, 6'h00, 1'b0, 6'h15, 4'd0);
    vt[7]  = mk(2'b11, 6'h02, 6'h01, 1'b0, 6'h15, 4'd2);
    vt[8]  = mk(2'b00, 6'h00, 6'h00, 1'b1, 6'h02, 4'd1);
    vt[9]  = mk(2'b00, 6'h00, 6'h00, 1'b1, 6'h01, 4'd0);
    vt[10] = mk(2'b00, 6'h00, 6'h00, 1'b0, 6'h01, 4'd0);
`endif

    // Reset state.
    bus.src_valid = '0;
    bus.src_tag   = '0;
    bus.flush     = 1'b0;
    #1;
    check("rst_exec_done", 32'(bus.exec_done), 32'd0);
    check("rst_exec_dest_prf", 32'(bus.exec_dest_prf), 32'd0);
    check("rst_pending_cnt", 32'(bus.pending_cnt), 32'd0);
    check("rst_src_ready", 32'(bus.src_ready), 32'h3);
    @(negedge clk);
    do_reset();

    // Simultaneous completion, single completion, round-robin pointer.
    foreach (vt[i]) begin
      bus.src_valid = vt[i].v;
      bus.src_tag   = vt[i].t;
      @(posedge clk);
      @(negedge clk);
      bus.src_valid = '0;
      check($sformatf("vec%0d_done", i), 32'(bus.exec_done), 32'(vt[i].exp_done));
      check($sformatf("vec%0d_tag", i), 32'(bus.exec_dest_prf), 32'(vt[i].exp_tag));
      check($sformatf("vec%0d_pend", i), 32'(bus.pending_cnt), 32'(vt[i].exp_pend));
    end

    // Fairness and full FIFO: both sources push unique tags for 8 cycles.
    do_reset();
    accepted = 0; broadcast = 0; saw_not_ready = 1'b0;
    refused.delete(); sent.delete();
    for (int c = 0; c < 8; c++) begin
      step(2'b11, {6'(6'h20 + c), 6'(c)}, 1'b0);
    end
    for (lim = 0; lim < 40 && mq.size() != 0; lim++) step('0, '0, 1'b0);
    idle_steps(1);
    check("drain_pending", 32'(bus.pending_cnt), 32'd0);
    check("ready_deasserted", 32'(saw_not_ready), 32'd1);
    check("broadcast_eq_accepted", 32'(broadcast), 32'(accepted));
    foreach (refused[i]) begin
      hit = 0;
      foreach (sent[j]) if (sent[j] == refused[i]) hit++;
      check($sformatf("refused_%0h_sent", refused[i]), 32'(hit), 32'd0);
    end

    // Flush with at least 5 entries pending plus a simultaneous push.
    do_reset();
    seq = 6'd0;
    for (lim = 0; lim < 20 && mq.size() < 5; lim++) begin
      step(2'b11, {6'h20 | seq, seq}, 1'b0);
      seq = seq + 6'd1;
    end
    check("flush_prefill", 32'(mq.size() >= 5), 32'd1);
    step(2'b11, {6'h3E, 6'h1E}, 1'b1);
    check("flush_done", 32'(bus.exec_done), 32'd0);
    check("flush_pend", 32'(bus.pending_cnt), 32'd0);
    hit = 0;
    for (int i = 0; i < 5; i++) begin
      step('0, '0, 1'b0);
      if (bus.exec_done !== 1'b0) hit++;
    end
    check("flush_no_done_after", 32'(hit), 32'd0);

    // Reset asserted mid-drain with 3 entries queued.
    do_reset();
    for (lim = 0; lim < 20 && mq.size() < 3; lim++) step(2'b11, {6'h31, 6'h11}, 1'b0);
    check("rst_prefill", 32'(mq.size()), 32'd3);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_exec_done", 32'(bus.exec_done), 32'd0);
    check("midrst_pending", 32'(bus.pending_cnt), 32'd0);
    check("midrst_src_ready", 32'(bus.src_ready), 32'h3);
    m_clear();
    m_tag = '0;
    @(negedge clk);
    reset_n = 1'b1;
    hit = 0;
    for (int i = 0; i < 4; i++) begin
      step('0, '0, 1'b0);
      if (bus.exec_done !== 1'b0) hit++;
    end
    check("midrst_no_stale", 32'(hit), 32'd0);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      step(NUM_SRC'($urandom_range(0, (1 << NUM_SRC) - 1)),
           (NUM_SRC*TAG_W)'($urandom),
           ($urandom_range(0, 24) == 0));
    end
    idle_steps(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
